led_pattern_seq: RTL and testbench

AXI4-Lite master controller that autonomously drives the `led_ip` slave register file. On each programmable tick it computes the next LED pattern, writes it to the next slave register in round-robin order, reads the register back, and checks the returned value. It sits between the PL clock/reset domain and the `led_ip` S00_AXI port, or an interconnect slot feeding it. It replaces software polling for free-running LED animations and continuously self-checks the register path.

---
 rtl/led_pattern_seq.sv | 245 ++++++++++++++++++++++++
 tb/tb_led_pattern_seq.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_seq.sv
// AXI4-Lite master that periodically writes an LED pattern into the led_ip registers,
// reads each register back and flags any mismatch or error response.
module led_pattern_seq #(
    parameter int unsigned C_AXI_ADDR_WIDTH = 4,
    parameter int unsigned C_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_NUM_REGS       = 4,
    parameter int unsigned C_TICK_DIV       = 100000
) (
    input  logic                              ACLK,
    input  logic                              ARESETN,
    input  logic                              enable,
    input  logic                              mode,
    output logic                              busy,
    output logic                              err,
    output logic [7:0]                        err_count,
    output logic [C_AXI_DATA_WIDTH-1:0]       pattern,
    output logic [C_AXI_ADDR_WIDTH-1:0]       m_axi_awaddr,
    output logic [2:0]                        m_axi_awprot,
    output logic                              m_axi_awvalid,
    input  logic                              m_axi_awready,
    output logic [C_AXI_DATA_WIDTH-1:0]       m_axi_wdata,
    output logic [C_AXI_DATA_WIDTH/8-1:0]     m_axi_wstrb,
    output logic                              m_axi_wvalid,
    input  logic                              m_axi_wready,
    input  logic [1:0]                        m_axi_bresp,
    input  logic                              m_axi_bvalid,
    output logic                              m_axi_bready,
    output logic [C_AXI_ADDR_WIDTH-1:0]       m_axi_araddr,
    output logic [2:0]                        m_axi_arprot,
    output logic                              m_axi_arvalid,
    input  logic                              m_axi_arready,
    input  logic [C_AXI_DATA_WIDTH-1:0]       m_axi_rdata,
    input  logic [1:0]                        m_axi_rresp,
    input  logic                              m_axi_rvalid,
    output logic                              m_axi_rready
);

    localparam int unsigned DATA_W  = C_AXI_DATA_WIDTH;
    localparam int unsigned ADDR_W  = C_AXI_ADDR_WIDTH;
    localparam int unsigned CNT_W   = $clog2(C_TICK_DIV);
    localparam int unsigned IDX_W   = 2;
    localparam int unsigned ECNT_W  = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_WB,
        S_RA,
        S_RD,
        S_CHK
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    tick_cnt_q;
    logic                tick_c;
    logic                pend_q, pend_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [DATA_W-1:0]   pattern_q, pattern_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                awvalid_q, awvalid_d;
    logic                wvalid_q, wvalid_d;
    logic                bready_q, bready_d;
    logic                arvalid_q, arvalid_d;
    logic                rready_q, rready_d;
    logic                busy_q, busy_d;
    logic                err_q, err_d;
    logic [ECNT_W-1:0]   err_cnt_q, err_cnt_d;
    logic [1:0]          bresp_q, bresp_d;
    logic [1:0]          rresp_q, rresp_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    logic [DATA_W-1:0]   next_pat_c;
    logic [IDX_W-1:0]    idx_next_c;
    logic [ADDR_W-1:0]   addr_next_c;
    logic                chk_fail_c;

    // Free-running tick divider; the tick is the wrap cycle.
    assign tick_c = (tick_cnt_q == CNT_W'(C_TICK_DIV - 1));

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            tick_cnt_q <= '0;
        end else if (tick_c) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_q + CNT_W'(1);
        end
    end

    // Rotate mode reseeds from 1 so an all-zero pattern cannot stick.
    always_comb begin
        if (mode) begin
            next_pat_c = (pattern_q == '0) ? DATA_W'(1)
                                           : {pattern_q[DATA_W-2:0], pattern_q[DATA_W-1]};
        end else begin
            next_pat_c = pattern_q + DATA_W'(1);
        end
    end

    assign idx_next_c  = (idx_q == IDX_W'(C_NUM_REGS - 1)) ? '0 : idx_q + IDX_W'(1);
    assign addr_next_c = ADDR_W'({idx_q, 2'b00});
    assign chk_fail_c  = (bresp_q != 2'b00) || (rresp_q != 2'b00) || (rdata_q != pattern_q);

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state_q   <= S_IDLE;
            pend_q    <= 1'b0;
            idx_q     <= '0;
            pattern_q <= '0;
            addr_q    <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
            bresp_q   <= 2'b00;
            rresp_q   <= 2'b00;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            pend_q    <= pend_d;
            idx_q     <= idx_d;
            pattern_q <= pattern_d;
            addr_q    <= addr_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
            bresp_q   <= bresp_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
        end
    end

    // Next-state and next-output logic for one write/read-back transaction.
    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q;
        idx_d     = idx_q;
        pattern_d = pattern_q;
        addr_d    = addr_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        err_d     = err_q;
        err_cnt_d = err_cnt_q;
        bresp_d   = bresp_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;

        unique case (state_q)
            S_IDLE: begin
                if (pend_q) begin
                    pend_d    = 1'b0;
                    pattern_d = next_pat_c;
                    addr_d    = addr_next_c;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    state_d   = S_WR;
                end
            end
            S_WR: begin
                if (awvalid_q && m_axi_awready) begin
                    awvalid_d = 1'b0;
                end
                if (wvalid_q && m_axi_wready) begin
                    wvalid_d = 1'b0;
                end
                if (!awvalid_d && !wvalid_d) begin
                    bready_d = 1'b1;
                    state_d  = S_WB;
                end
            end
            S_WB: begin
                if (m_axi_bvalid) begin
                    bresp_d   = m_axi_bresp;
                    bready_d  = 1'b0;
                    arvalid_d = 1'b1;
                    state_d   = S_RA;
                end
            end
            S_RA: begin
                if (m_axi_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = S_RD;
                end
            end
            S_RD: begin
                if (m_axi_rvalid) begin
                    rdata_d  = m_axi_rdata;
                    rresp_d  = m_axi_rresp;
                    rready_d = 1'b0;
                    state_d  = S_CHK;
                end
            end
            S_CHK: begin
                if (chk_fail_c) begin
                    err_d = 1'b1;
                    if (err_cnt_q != '1) begin
                        err_cnt_d = err_cnt_q + ECNT_W'(1);
                    end
                end
                idx_d   = idx_next_c;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A tick landing in the consuming cycle re-arms pend instead of being lost.
        if (tick_c && enable) begin
            pend_d = 1'b1;
        end

        busy_d = (state_d != S_IDLE);
    end

    assign busy          = busy_q;
    assign err           = err_q;
    assign err_count     = err_cnt_q;
    assign pattern       = pattern_q;
    assign m_axi_awaddr  = addr_q;
    assign m_axi_araddr  = addr_q;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wdata   = pattern_q;
    assign m_axi_wstrb   = '1;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_bready  = bready_q;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_rready  = rready_q;

endmodule

// File: tb/tb_led_pattern_seq.sv
// Directed bench for led_pattern_seq with a reactive AXI4-Lite register-file slave
// that supports per-channel stalls and injected read/write faults.
module tb_led_pattern_seq;

    localparam int unsigned AW  = 4;
    localparam int unsigned DIV = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        mode;
    logic        busy;
    logic        err;
    logic [7:0]  err_count;
    logic [31:0] pattern;
    logic [AW-1:0] awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;

    int errors = 0;
    int checks = 0;

    // slave configuration
    int aw_delay, w_delay, b_delay, ar_delay, r_delay;
    int bad_read_n, bad_write_n;
    bit corrupt_all;

    // slave state and monitors
    logic [31:0] mem [4];
    int aw_wait, w_wait, b_wait, ar_wait, r_wait;
    bit got_aw, got_w, rd_pend;
    bit aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic [AW-1:0] wa, ra;
    logic [31:0] wd;
    int n_writes, n_reads, aw_hs_cnt, w_hs_cnt, aw_hi, w_hi, stab_viol, overlap_viol;
    logic [AW-1:0] wr_addr_log [$];
    logic [31:0]   wr_data_log [$];
    bit p_awv, p_wv, p_arv, p_br, p_rr;
    logic [AW-1:0] p_awaddr, p_araddr;
    logic [31:0]   p_wdata;

    always #5 clk = ~clk;

    led_pattern_seq #(
        .C_AXI_ADDR_WIDTH(AW),
        .C_AXI_DATA_WIDTH(32),
        .C_NUM_REGS(4),
        .C_TICK_DIV(DIV)
    ) dut (
        .ACLK(clk), .ARESETN(rst_n), .enable(enable), .mode(mode),
        .busy(busy), .err(err), .err_count(err_count), .pattern(pattern),
        .m_axi_awaddr(awaddr), .m_axi_awprot(awprot), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
        .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
        .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
        .m_axi_araddr(araddr), .m_axi_arprot(arprot), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
        .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
    );

    // Slave: acts on the falling edge; handshakes are judged from values held over the last rising edge.
    initial begin : slave
        awready = 0; wready = 0; bvalid = 0; bresp = 0; arready = 0; rvalid = 0; rdata = 0; rresp = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                awready = 0; wready = 0; bvalid = 0; bresp = 0; arready = 0; rvalid = 0; rdata = 0; rresp = 0;
                aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
                got_aw = 0; got_w = 0; rd_pend = 0;
                for (int i = 0; i < 4; i++) mem[i] = 32'h0;
                p_awv = 0; p_wv = 0; p_arv = 0; p_br = 0; p_rr = 0;
                p_awaddr = '0; p_araddr = '0; p_wdata = '0;
            end else begin
                aw_hs = p_awv && awready;
                w_hs  = p_wv && wready;
                b_hs  = bvalid && p_br;
                ar_hs = p_arv && arready;
                r_hs  = rvalid && p_rr;
                if (p_awv && !aw_hs && (!awvalid || awaddr !== p_awaddr)) stab_viol++;
                if (p_wv && !w_hs && (!wvalid || wdata !== p_wdata)) stab_viol++;
                if (p_arv && !ar_hs && (!arvalid || araddr !== p_araddr)) stab_viol++;
                if ((awvalid || wvalid) && (arvalid || bready || rready)) overlap_viol++;
                if (aw_hs) begin got_aw = 1; wa = p_awaddr; aw_hs_cnt++; aw_wait = 0; end
                if (w_hs) begin got_w = 1; wd = p_wdata; w_hs_cnt++; w_wait = 0; end
                if (b_hs) bvalid = 0;
                if (r_hs) rvalid = 0;
                if (ar_hs) begin rd_pend = 1; ra = p_araddr; r_wait = 0; ar_wait = 0; end
                if (got_aw && got_w && !bvalid) begin
                    if (b_wait >= b_delay) begin
                        n_writes++;
                        mem[wa[3:2]] = wd;
                        wr_addr_log.push_back(wa);
                        wr_data_log.push_back(wd);
                        bresp = (n_writes == bad_write_n) ? 2'b10 : 2'b00;
                        bvalid = 1; got_aw = 0; got_w = 0; b_wait = 0;
                    end else b_wait++;
                end
                if (rd_pend && !rvalid) begin
                    if (r_wait >= r_delay) begin
                        n_reads++;
                        rdata = mem[ra[3:2]];
                        if (corrupt_all || n_reads == bad_read_n) rdata = rdata ^ 32'h1;
                        rresp = 2'b00; rvalid = 1; rd_pend = 0;
                    end else r_wait++;
                end
                awready = 0;
                if (awvalid) begin
                    aw_hi++;
                    if (aw_wait >= aw_delay) awready = 1; else aw_wait++;
                end
                wready = 0;
                if (wvalid) begin
                    w_hi++;
                    if (w_wait >= w_delay) wready = 1; else w_wait++;
                end
                arready = 0;
                if (arvalid) begin
                    if (ar_wait >= ar_delay) arready = 1; else ar_wait++;
                end
                p_awv = awvalid; p_wv = wvalid; p_arv = arvalid; p_br = bready; p_rr = rready;
                p_awaddr = awaddr; p_araddr = araddr; p_wdata = wdata;
            end
        end
    end

    task automatic apply_reset(input bit en, input bit md);
        rst_n = 0; enable = 0; mode = 0;
        aw_delay = 0; w_delay = 0; b_delay = 0; ar_delay = 0; r_delay = 0;
        bad_read_n = 0; bad_write_n = 0; corrupt_all = 0;
        repeat (3) @(posedge clk);
        #1;
        n_writes = 0; n_reads = 0; aw_hs_cnt = 0; w_hs_cnt = 0; aw_hi = 0; w_hi = 0;
        stab_viol = 0; overlap_viol = 0;
        wr_addr_log.delete(); wr_data_log.delete();
        enable = en; mode = md;
        rst_n = 1;
    endtask

    task automatic wait_writes(input int n, input int budget, output bit ok);
        int c;
        c = 0; ok = 0;
        while (c < budget) begin
            @(posedge clk); #1; c++;
            if (wr_data_log.size() >= n) begin ok = 1; break; end
        end
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        int c;
        c = 0; ok = 0;
        while (c < budget) begin
            @(posedge clk); #1; c++;
            if (busy === 1'b0) begin ok = 1; break; end
        end
    endtask

    task automatic test_reset();
        rst_n = 0; enable = 0; mode = 0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %0b want 0", err); end
        checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL reset_err_count: got %0d want 0", err_count); end
        checks++; if (pattern !== 32'h0) begin errors++; $display("FAIL reset_pattern: got %h want 0", pattern); end
        checks++; if ({awvalid, wvalid, arvalid, bready, rready} !== 5'b0) begin
            errors++; $display("FAIL reset_handshakes: got %b want 00000", {awvalid, wvalid, arvalid, bready, rready}); end
        checks++; if (awaddr !== 4'h0 || araddr !== 4'h0) begin
            errors++; $display("FAIL reset_addr: got aw=%h ar=%h want 0", awaddr, araddr); end
        checks++; if (wdata !== 32'h0) begin errors++; $display("FAIL reset_wdata: got %h want 0", wdata); end
        checks++; if (awprot !== 3'b000 || arprot !== 3'b000 || wstrb !== 4'hF) begin
            errors++; $display("FAIL reset_const: got awprot=%b arprot=%b wstrb=%h want 000 000 F", awprot, arprot, wstrb); end
    endtask

    task automatic test_increment();
        int k, bcnt;
        bit ok;
        logic [31:0] d;
        logic [3:0] a;
        apply_reset(1, 0);
        k = 0;
        while (k < 40) begin
            @(posedge clk); #1; k++;
            if (awvalid === 1'b1) break;
        end
        // tick in cycle 15, pend at edge 15, awvalid at edge 16 -> 17th sample
        checks++; if (k != 17) begin errors++; $display("FAIL inc_first_awvalid_latency: got %0d want 17", k); end
        bcnt = 0;
        while (busy === 1'b1 && bcnt < 40) begin bcnt++; @(posedge clk); #1; end
        checks++; if (bcnt != 5) begin errors++; $display("FAIL inc_busy_cycles: got %0d want 5", bcnt); end
        wait_writes(5, 200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL inc_timeout: got %0d writes want 5", wr_data_log.size()); end
        wait_idle(40, ok);
        for (int i = 0; i < 5; i++) begin
            d = (i < wr_data_log.size()) ? wr_data_log[i] : 32'hx;
            a = (i < wr_addr_log.size()) ? wr_addr_log[i] : 4'hx;
            checks++; if (d !== 32'(i + 1) || a !== 4'((i % 4) * 4)) begin
                errors++; $display("FAIL inc_write%0d: got addr=%h data=%h want addr=%h data=%h", i, a, d, 4'((i % 4) * 4), 32'(i + 1)); end
        end
        checks++; if (err !== 1'b0 || err_count !== 8'd0) begin
            errors++; $display("FAIL inc_err: got err=%0b cnt=%0d want 0 0", err, err_count); end
    endtask

    task automatic test_rotate();
        bit ok;
        int bad;
        logic [31:0] expv, d;
        apply_reset(1, 1);
        wait_writes(33, 1000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rot_timeout: got %0d writes want 33", wr_data_log.size()); end
        wait_idle(40, ok);
        bad = 0;
        for (int i = 0; i < 33; i++) begin
            expv = 32'h1 << (i % 32);
            d = (i < wr_data_log.size()) ? wr_data_log[i] : 32'hx;
            checks++; if (d !== expv) begin
                errors++; $display("FAIL rot_pattern%0d: got %h want %h", i, d, expv); end
        end
        checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL rot_err_count: got %0d want 0", err_count); end
    endtask

    task automatic test_stall();
        int k;
        bit ok;
        apply_reset(1, 0);
        aw_delay = 3; w_delay = 7; b_delay = 5;
        k = 0;
        while (k < 40 && awvalid !== 1'b1) begin @(posedge clk); #1; k++; end
        enable = 0;
        wait_writes(1, 100, ok);
        checks++; if (!ok) begin errors++; $display("FAIL stall_timeout: got %0d writes want 1", wr_data_log.size()); end
        wait_idle(60, ok);
        repeat (40) @(posedge clk);
        #1;
        checks++; if (aw_hi != 4) begin errors++; $display("FAIL stall_awvalid_cycles: got %0d want 4", aw_hi); end
        checks++; if (w_hi != 8) begin errors++; $display("FAIL stall_wvalid_cycles: got %0d want 8", w_hi); end
        checks++; if (aw_hs_cnt != 1 || w_hs_cnt != 1) begin
            errors++; $display("FAIL stall_single_write: got aw=%0d w=%0d want 1 1", aw_hs_cnt, w_hs_cnt); end
        checks++; if (stab_viol != 0) begin errors++; $display("FAIL stall_stability: got %0d violations want 0", stab_viol); end
        checks++; if (wr_data_log.size() != 1 || wr_data_log[0] !== 32'h1 || wr_addr_log[0] !== 4'h0) begin
            errors++; $display("FAIL stall_write_value: got %0d writes want one write of 1 to 0x0", wr_data_log.size()); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL stall_err: got %0b want 0", err); end
    endtask

    task automatic test_fault();
        bit ok;
        apply_reset(1, 0);
        bad_read_n = 2; bad_write_n = 4;
        wait_writes(5, 200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL fault_timeout: got %0d writes want 5", wr_data_log.size()); end
        wait_idle(40, ok);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL fault_err: got %0b want 1", err); end
        checks++; if (err_count !== 8'd2) begin errors++; $display("FAIL fault_err_count: got %0d want 2", err_count); end
        corrupt_all = 1;
        wait_writes(305, 5600, ok);
        checks++; if (!ok) begin errors++; $display("FAIL sat_timeout: got %0d writes want 305", wr_data_log.size()); end
        wait_idle(40, ok);
        checks++; if (err_count !== 8'd255) begin errors++; $display("FAIL sat_err_count: got %0d want 255", err_count); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL sat_err: got %0b want 1", err); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int n;
        apply_reset(1, 0);
        b_delay = 20; r_delay = 20;
        repeat (300) @(posedge clk);
        #1;
        enable = 0;
        wait_idle(100, ok);
        checks++; if (!ok) begin errors++; $display("FAIL b2b_idle_timeout: got busy=%0b want 0", busy); end
        n = wr_data_log.size();
        // ~18 ticks in the window but each transaction takes ~47 cycles
        checks++; if (n < 3 || n > 8) begin errors++; $display("FAIL b2b_txn_count: got %0d want 3..8", n); end
        for (int i = 0; i < n; i++) begin
            checks++; if (wr_data_log[i] !== 32'(i + 1) || wr_addr_log[i] !== 4'((i % 4) * 4)) begin
                errors++; $display("FAIL b2b_write%0d: got addr=%h data=%h want addr=%h data=%h",
                                   i, wr_addr_log[i], wr_data_log[i], 4'((i % 4) * 4), 32'(i + 1)); end
        end
        checks++; if (n_reads != n || aw_hs_cnt != n) begin
            errors++; $display("FAIL b2b_one_per_txn: got reads=%0d aw=%0d want %0d", n_reads, aw_hs_cnt, n); end
        checks++; if (overlap_viol != 0) begin errors++; $display("FAIL b2b_overlap: got %0d want 0", overlap_viol); end
        checks++; if (stab_viol != 0) begin errors++; $display("FAIL b2b_stability: got %0d want 0", stab_viol); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL b2b_err: got %0b want 0", err); end
    endtask

    task automatic test_reset_mid();
        int k;
        bit ok;
        logic [31:0] d;
        logic [3:0] a;
        apply_reset(1, 0);
        r_delay = 10;
        k = 0;
        while (k < 60 && rready !== 1'b1) begin @(posedge clk); #1; k++; end
        checks++; if (rready !== 1'b1) begin errors++; $display("FAIL rmid_reach_rd: got rready=%0b want 1", rready); end
        rst_n = 0;
        @(posedge clk);
        #1;
        checks++; if ({awvalid, wvalid, arvalid, bready, rready, busy, err} !== 7'b0) begin
            errors++; $display("FAIL rmid_flags: got %b want 0000000", {awvalid, wvalid, arvalid, bready, rready, busy, err}); end
        checks++; if (pattern !== 32'h0 || wdata !== 32'h0) begin
            errors++; $display("FAIL rmid_data: got pattern=%h wdata=%h want 0 0", pattern, wdata); end
        checks++; if (awaddr !== 4'h0 || araddr !== 4'h0 || err_count !== 8'd0) begin
            errors++; $display("FAIL rmid_addr_cnt: got aw=%h ar=%h cnt=%0d want 0 0 0", awaddr, araddr, err_count); end
        rst_n = 1;
        r_delay = 0;
        wr_addr_log.delete(); wr_data_log.delete();
        wait_writes(1, 60, ok);
        d = (wr_data_log.size() > 0) ? wr_data_log[0] : 32'hx;
        a = (wr_addr_log.size() > 0) ? wr_addr_log[0] : 4'hx;
        checks++; if (d !== 32'h1 || a !== 4'h0) begin
            errors++; $display("FAIL rmid_restart: got addr=%h data=%h want addr=0 data=1", a, d); end
        wait_idle(40, ok);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rmid_err: got %0b want 0", err); end
    endtask

    initial begin
        test_reset();
        test_increment();
        test_rotate();
        test_stall();
        test_fault();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
